// File: rtl/life_pkg.sv
// Shared types and helpers for the Game of Life LED scan stage.
// Grid bit 8*r+c is row r, column c.
package life_pkg;

   typedef enum logic [1:0] {IDLE, LOAD, SCAN, BLANK} scan_state_t;

   localparam int GRID_W = 64;
   localparam int ROW_W  = 8;
   localparam int N_ROWS = 8;

   function automatic logic [ROW_W-1:0] row_slice(input logic [GRID_W-1:0] g,
                                                  input logic [2:0]        r);
      return g[ROW_W*r +: ROW_W];
   endfunction

endpackage

// File: rtl/scan_timer.sv
// Loadable down-counter; done is high while the count sits at zero.
// A load takes priority over counting.
module scan_timer #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         load,
   input  logic [W-1:0] load_val,
   output logic         done
);

   logic [W-1:0] r_count;

   always_ff @(posedge clk) begin
      if (reset)
         r_count <= '0;
      else if (load)
         r_count <= load_val;
      else if (r_count != '0)
         r_count <= r_count - 1'b1;
   end

   assign done = (r_count == '0);

endmodule

// File: rtl/life_led_scan.sv
// 8x8 LED matrix row scanner with tear-free generation buffering.
// State encoding: IDLE -> LOAD -> (SCAN [-> BLANK]) x 8 -> LOAD/IDLE.
module life_led_scan
   import life_pkg::*;
#(
   parameter int DWELL = 1000,
   parameter int BLANK = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              enable,
   input  logic [GRID_W-1:0] grid,
   input  logic              grid_load,
   output logic [ROW_W-1:0]  row_sel,
   output logic [ROW_W-1:0]  col_data,
   output logic              frame_done,
   output logic              pending
);

   localparam int MAX_CNT = (DWELL > BLANK) ? DWELL : BLANK;
   localparam int CNT_W   = $clog2(MAX_CNT + 1);
   localparam logic [CNT_W-1:0] DWELL_LD = CNT_W'(DWELL - 1);
   localparam logic [CNT_W-1:0] BLANK_LD = CNT_W'((BLANK > 0) ? BLANK - 1 : 0);

   scan_state_t       r_state;
   logic [2:0]        r_row;
   logic [GRID_W-1:0] r_pend_buf;
   logic [GRID_W-1:0] r_disp_buf;
   logic              r_pending;
   logic              r_frame_done;

   scan_state_t       w_next_state;
   logic [2:0]        w_next_row;
   logic              w_tmr_load;
   logic [CNT_W-1:0]  w_tmr_val;
   logic              w_tmr_done;
   logic              w_row_done;
   logic              w_frame_end;

   scan_timer #(.W(CNT_W)) u_timer (
      .clk      (clk),
      .reset    (reset),
      .load     (w_tmr_load),
      .load_val (w_tmr_val),
      .done     (w_tmr_done)
   );

   always_comb begin
      w_next_state = r_state;
      w_next_row   = r_row;
      w_tmr_load   = 1'b0;
      w_tmr_val    = DWELL_LD;
      w_row_done   = 1'b0;
      w_frame_end  = 1'b0;
      case (r_state)
         IDLE: begin
            w_next_row = 3'd0;
            if (enable) w_next_state = LOAD;
         end
         LOAD: begin
            w_next_row   = 3'd0;
            w_next_state = SCAN;
            w_tmr_load   = 1'b1;
         end
         SCAN: begin
            if (w_tmr_done) begin
               if (BLANK > 0) begin
                  w_next_state = life_pkg::BLANK;
                  w_tmr_load   = 1'b1;
                  w_tmr_val    = BLANK_LD;
               end else begin
                  w_row_done = 1'b1;
               end
            end
         end
         life_pkg::BLANK: begin
            if (w_tmr_done) w_row_done = 1'b1;
         end
         default: w_next_state = IDLE;
      endcase
      // Row 7 never wraps here; a new frame restarts only through LOAD.
      if (w_row_done) begin
         if (r_row != 3'd7) begin
            w_next_row   = r_row + 3'd1;
            w_next_state = SCAN;
            w_tmr_load   = 1'b1;
            w_tmr_val    = DWELL_LD;
         end else begin
            w_frame_end  = 1'b1;
            w_next_state = enable ? LOAD : IDLE;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state      <= IDLE;
         r_row        <= 3'd0;
         r_pend_buf   <= '0;
         r_disp_buf   <= '0;
         r_pending    <= 1'b0;
         r_frame_done <= 1'b0;
      end else begin
         r_state      <= w_next_state;
         r_row        <= w_next_row;
         r_frame_done <= w_frame_end;
         if (grid_load) r_pend_buf <= grid;
         // A strobe landing on LOAD bypasses pend_buf so it is shown this frame.
         if (r_state == LOAD) begin
            if (grid_load)
               r_disp_buf <= grid;
            else if (r_pending)
               r_disp_buf <= r_pend_buf;
            r_pending <= 1'b0;
         end else if (grid_load) begin
            r_pending <= 1'b1;
         end
      end
   end

   assign row_sel    = (r_state == SCAN) ? (8'd1 << r_row) : '0;
   assign col_data   = (r_state == SCAN) ? row_slice(r_disp_buf, r_row) : '0;
   assign frame_done = r_frame_done;
   assign pending    = r_pending;

endmodule

// File: tb/tb_life_led_scan.sv
// Bench for life_led_scan: directed scenarios then random traffic, checked
// against a frame-position model of the display.
module tb_life_led_scan;

   localparam int D  = 4;
   localparam int B  = 2;
   localparam int RP = D + B;
   localparam int FP = 1 + 8 * RP;

   logic        clk = 1'b0;
   logic        reset;
   logic        enable;
   logic [63:0] grid;
   logic        grid_load;
   logic [7:0]  row_sel;
   logic [7:0]  col_data;
   logic        frame_done;
   logic        pending;

   int vectors     = 0;
   int miscompares = 0;

   // model: m_run=false is idle; otherwise m_t is the position in the frame,
   // 0 being the load cycle and 1..FP-1 the row slots.
   bit          m_run;
   int          m_t;
   logic [63:0] m_disp;
   logic [63:0] m_pend;
   bit          m_pflag;
   bit          m_fd;

   life_led_scan #(.DWELL(D), .BLANK(B)) dut (
      .clk        (clk),
      .reset      (reset),
      .enable     (enable),
      .grid       (grid),
      .grid_load  (grid_load),
      .row_sel    (row_sel),
      .col_data   (col_data),
      .frame_done (frame_done),
      .pending    (pending)
   );

   always #5 clk = ~clk;

   task automatic model_update();
      bit was_load;
      if (reset) begin
         m_run = 0; m_t = 0; m_disp = '0; m_pend = '0; m_pflag = 0; m_fd = 0;
      end else begin
         was_load = m_run && (m_t == 0);
         m_fd = 0;
         if (was_load) begin
            if (grid_load) m_disp = grid;
            else if (m_pflag) m_disp = m_pend;
            m_pflag = 0;
         end else if (grid_load) begin
            m_pflag = 1;
         end
         if (grid_load) m_pend = grid;
         if (!m_run) begin
            if (enable) begin m_run = 1; m_t = 0; end
         end else if (m_t == FP - 1) begin
            m_fd = 1;
            m_t  = 0;
            if (!enable) m_run = 0;
         end else begin
            m_t++;
         end
      end
   endtask

   task automatic check_model();
      logic [7:0] exp_rs;
      logic [7:0] exp_col;
      int r;
      int off;
      exp_rs  = '0;
      exp_col = '0;
      if (m_run && m_t >= 1) begin
         r   = (m_t - 1) / RP;
         off = (m_t - 1) % RP;
         if (off < D) begin
            exp_rs  = 8'(1 << r);
            exp_col = m_disp[8*r +: 8];
         end
      end
      vectors++;
      assert (row_sel === exp_rs) else begin
         miscompares++;
         $error("FAIL row_sel obs=%h exp=%h at %0t", row_sel, exp_rs, $time);
      end
      vectors++;
      assert (col_data === exp_col) else begin
         miscompares++;
         $error("FAIL col_data obs=%h exp=%h at %0t", col_data, exp_col, $time);
      end
      vectors++;
      assert (frame_done === m_fd) else begin
         miscompares++;
         $error("FAIL frame_done obs=%b exp=%b at %0t", frame_done, m_fd, $time);
      end
      vectors++;
      assert (pending === m_pflag) else begin
         miscompares++;
         $error("FAIL pending obs=%b exp=%b at %0t", pending, m_pflag, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      model_update();
      #1;
      check_model();
   endtask

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
      vectors++;
      assert (obs === exp_v) else begin
         miscompares++;
         $error("FAIL %s obs=%h exp=%h at %0t", tag, obs, exp_v, $time);
      end
   endtask

   task automatic run_until(input int target);
      for (int i = 0; i < 200 && !(m_run && m_t == target); i++) step();
      vectors++;
      assert (m_run && m_t == target) else begin
         miscompares++;
         $error("FAIL run_until obs=%0d exp=%0d", m_t, target);
      end
   endtask

   initial begin
      int n;
      reset = 1'b1; enable = 1'b0; grid = '0; grid_load = 1'b0;
      step(); step();
      reset = 1'b0;
      for (int i = 0; i < 5; i++) step();
      chk("idle_row_sel", row_sel, 8'h00);

      // scan order
      grid = 64'h8040_2010_0804_0201; grid_load = 1'b1;
      step();
      grid_load = 1'b0;
      chk("pending_set", {7'd0, pending}, 8'h01);
      enable = 1'b1;
      step();
      n = 0;
      for (int i = 1; i <= 100; i++) begin
         step();
         if (frame_done === 1'b1) begin n = i; break; end
      end
      chk("frame_done_cycle", 8'(n), 8'd49);

      // no tearing: new generation arrives during row 3
      run_until(20);
      grid = 64'hFFFF_FFFF_FFFF_FFFF; grid_load = 1'b1;
      step();
      grid_load = 1'b0;
      chk("tear_pending", {7'd0, pending}, 8'h01);
      run_until(38);
      chk("tear_row6_old", col_data, 8'h40);
      run_until(0);
      step();
      chk("tear_new_col", col_data, 8'hFF);
      chk("tear_pend_clr", {7'd0, pending}, 8'h00);

      // strobe collision in LOAD
      run_until(0);
      grid = 64'h0000_0000_0000_00FF; grid_load = 1'b1;
      step();
      grid_load = 1'b0;
      chk("coll_row_sel", row_sel, 8'h01);
      chk("coll_col", col_data, 8'hFF);
      chk("coll_pending", {7'd0, pending}, 8'h00);

      // enable drop during row 2
      run_until(14);
      enable = 1'b0;
      for (int i = 0; i < 100 && frame_done !== 1'b1; i++) step();
      chk("drop_frame_done", {7'd0, frame_done}, 8'h01);
      step(); step(); step();
      chk("drop_idle", row_sel, 8'h00);
      enable = 1'b1;
      step();
      step();
      chk("relaunch_row0", row_sel, 8'h01);

      // mid-frame reset during row 5
      run_until(32);
      reset = 1'b1; grid = 64'hDEAD_BEEF_0123_4567; grid_load = 1'b1;
      step();
      reset = 1'b0; grid_load = 1'b0;
      chk("rst_row_sel", row_sel, 8'h00);
      chk("rst_col", col_data, 8'h00);
      step(); step();
      chk("rst_row0_sel", row_sel, 8'h01);
      chk("rst_row0_col", col_data, 8'h00);
      run_until(25);
      chk("rst_row4_col", col_data, 8'h00);

      // random traffic
      for (int i = 0; i < 800; i++) begin
         grid      = {$urandom, $urandom};
         grid_load = ($urandom_range(0, 7) == 0);
         enable    = ($urandom_range(0, 15) != 0);
         reset     = ($urandom_range(0, 199) == 0);
         step();
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/life_led_scan.md
# life_led_scan

Downstream display stage for the Game of Life core: consumes the 64-bit generation register and drives an 8x8 LED matrix by time-multiplexed row scanning. A pending buffer captures each new generation on strobe, and a display buffer swaps it in only at a frame boundary, so a displayed frame never tears. An FSM sequences each row through a dwell interval and a blanking interval that suppresses ghosting.

## Interface
Parameters:
- DWELL, 1000: clock cycles each row is driven; legal range ≥1.
- BLANK, 8: all-off cycles after each row; 0 removes the BLANK state entirely.

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high; one clock, one reset.
- enable  in  1  scan run request; sampled only in IDLE and at frame end.
- grid  in  64  generation to display; bit 8*r+c is row r, column c.
- grid_load  in  1  single-cycle strobe: grid holds a new generation.
- row_sel  out  8  one-hot row drive, active-high; bit r drives row r.
- col_data  out  8  column drive, active-high; equals grid bits [8*r+7:8*r] for the active row r.
- frame_done  out  1  one-cycle pulse after row 7 completes.
- pending  out  1  high while pend_buf holds a generation not yet displayed.

## Operation
- Buffers:
  - pend_buf (64b): loaded from grid on every grid_load cycle; sets pending. A later strobe overwrites it; last-writer-wins.
  - disp_buf (64b): written only in LOAD. If pending, disp_buf←pend_buf and pending clears.
- FSM states:
  - IDLE: outputs 0; row=0. enable=1 → LOAD.
  - LOAD: exactly 1 cycle; outputs 0; buffer swap; row=0 → SCAN.
  - SCAN: row_sel=1<<row, col_data=disp_buf[8*row+:8] for DWELL cycles → BLANK, or skip BLANK when BLANK=0 and go straight to the next-row decision.
  - BLANK: outputs 0 for BLANK cycles. Then row<7 → row+1, SCAN. Row=7 → LOAD if enable, else IDLE.
- Simultaneous grid_load in LOAD: the swap takes grid directly (bypass), and pending stays 0 after that cycle.
- Simultaneous grid_load in any other state: pend_buf updates and pending=1.
- enable deasserted mid-frame: the current frame completes all 8 rows, then the FSM enters IDLE. There is no partial frame.
- Reset: state=IDLE, row=0, counter=0, pend_buf=disp_buf=0, pending=0. All outputs 0 the cycle after the reset edge.
- Reset mid-frame: aborts immediately. grid_load in the same cycle as reset is ignored.
- Arithmetic:
  - row: 3-bit and never wraps implicitly; the 7→0 transition goes only through LOAD.
  - Dwell counter width: $clog2(max(DWELL,BLANK)+1). It loads DWELL-1 or BLANK-1 and counts down to 0.

## Timing
- All outputs are decoded from registered state and buffers only; there is no combinational path from inputs to outputs.
- enable high at edge E in IDLE:
  - LOAD is the cycle after E.
  - row 0 is driven from E+2 for DWELL cycles.
- Frame period with enable held high: 1 + 8·(DWELL+BLANK) cycles.
- frame_done is high for exactly the cycle after the last cycle of row 7, coincident with LOAD or IDLE.
- Generation latency: grid_load to first display of that data is at most one frame period plus 2 cycles.
- pending is visible the cycle after the strobe.

## Structure
- Shared package life_pkg:
  - scan_state_t enum {IDLE, LOAD, SCAN, BLANK}.
  - GRID_W=64, ROW_W=8, N_ROWS=8.
  - Row-slice helper function.
- Sub-module scan_timer: loadable down-counter with a done flag, parameterised on width and instantiated once.
- Everything else (FSM, buffers, output decode) lives in life_led_scan.

## Test plan
- Reset/idle: reset 2 cycles, enable=0 → row_sel=0, col_data=0, frame_done=0, pending=0 indefinitely.
- Scan order (DWELL=4, BLANK=2): grid=64'h8040_2010_0804_0201, grid_load pulse, then enable=1.
  - LOAD, then row_sel=01/col=01 for 4 cycles, 2 cycles of 0, row_sel=02/col=02, … through row_sel=80/col=80.
  - frame_done pulses at cycle 49 after LOAD.
- No tearing: grid_load with 64'hFFFF_FFFF_FFFF_FFFF during row 3 → rows 3–7 keep the old data, pending=1. The next frame shows col=FF on every row, and pending clears in LOAD.
- Strobe collision: grid_load with 64'h00FF in the LOAD cycle → that frame shows row0 col=FF, and pending remains 0.
- Enable drop: enable falls during row 2 → rows 2–7 complete, frame_done pulses, then IDLE with outputs 0. Re-raising enable produces LOAD on the next cycle.
- Mid-frame reset: reset during row 5 SCAN → all outputs 0 the next cycle and disp_buf cleared. A subsequent enable shows col=00 on all rows.
